// File: rtl/alu_share_arbiter_pkg.sv
// Shared encodings and helpers for the shared-ALU arbiter: MIPS ALU op codes,
// FSM states and the carry/overflow ownership sets.
package alu_share_arbiter_pkg;

   localparam logic [3:0] AlucAddu = 4'd0;
   localparam logic [3:0] AlucSubu = 4'd1;
   localparam logic [3:0] AlucAdd  = 4'd2;
   localparam logic [3:0] AlucSub  = 4'd3;
   localparam logic [3:0] AlucAnd  = 4'd4;
   localparam logic [3:0] AlucOr   = 4'd5;
   localparam logic [3:0] AlucXor  = 4'd6;
   localparam logic [3:0] AlucNor  = 4'd7;
   localparam logic [3:0] AlucLui  = 4'd8;
   localparam logic [3:0] AlucSltu = 4'd10;
   localparam logic [3:0] AlucSlt  = 4'd11;
   localparam logic [3:0] AlucSra  = 4'd12;
   localparam logic [3:0] AlucSrl  = 4'd13;
   localparam logic [3:0] AlucSll  = 4'd14;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } state_e;

   // The ALU decodes 100x as LUI and 111x as SLL; fold aliases before set lookup.
   function automatic logic [3:0] polish_aluc(input logic [3:0] aluc);
      if (aluc[3:1] == 3'b100) begin
         return AlucLui;
      end else if (aluc[3:1] == 3'b111) begin
         return AlucSll;
      end
      return aluc;
   endfunction

   function automatic logic in_carry_set(input logic [3:0] aluc);
      return aluc inside {AlucAddu, AlucSubu, AlucSltu, AlucSra, AlucSrl, AlucSll};
   endfunction

   function automatic logic in_ovf_set(input logic [3:0] aluc);
      return aluc inside {AlucAdd, AlucSub};
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request found
// at or above the pointer, wrapping to index 0.
module alu_share_arbiter_rr_arbiter #(
   parameter int unsigned N    = 2,
   parameter int unsigned IdxW = 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o
);

   always_comb begin
      logic [IdxW-1:0] j;
      logic            found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = IdxW'((32'(ptr_i) + i) % N);
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational MIPS ALU between NREQ requesters, keeping
// a private copy of the sticky carry/overflow flags for each requester.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*4-1:0] req_aluc,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [W-1:0]      resp_r,
   output logic              resp_zero,
   output logic              resp_carry,
   output logic              resp_negative,
   output logic              resp_overflow,
   output logic [W-1:0]      alu_a,
   output logic [W-1:0]      alu_b,
   output logic [3:0]        alu_aluc,
   input  logic [W-1:0]      alu_r,
   input  logic              alu_zero,
   input  logic              alu_carry,
   input  logic              alu_negative,
   input  logic              alu_overflow,
   output logic              busy
);

   localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e          state_q, state_d;
   logic [IdxW-1:0] rr_q, rr_d;
   logic [IdxW-1:0] g_q, g_d;
   logic [W-1:0]    op_a_q, op_a_d;
   logic [W-1:0]    op_b_q, op_b_d;
   logic [3:0]      op_aluc_q, op_aluc_d;
   logic [W-1:0]    resp_r_q, resp_r_d;
   logic            zero_q, zero_d;
   logic            neg_q, neg_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic [NREQ-1:0] shadow_c_q, shadow_c_d;
   logic [NREQ-1:0] shadow_v_q, shadow_v_d;

   logic [NREQ-1:0] gnt;
   logic [IdxW-1:0] gnt_idx;
   logic [3:0]      aluc_pol;
   logic            carry_sel;
   logic            ovf_sel;

   alu_share_arbiter_rr_arbiter #(
      .N    (NREQ),
      .IdxW (IdxW)
   ) u_rr_arbiter (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // Flags the op leaves undefined fall back to the owning requester's shadow.
   assign aluc_pol  = polish_aluc(op_aluc_q);
   assign carry_sel = in_carry_set(aluc_pol) ? alu_carry : shadow_c_q[g_q];
   assign ovf_sel   = in_ovf_set(aluc_pol) ? alu_overflow : shadow_v_q[g_q];

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      g_d        = g_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_aluc_d  = op_aluc_q;
      resp_r_d   = resp_r_q;
      zero_d     = zero_q;
      neg_d      = neg_q;
      carry_d    = carry_q;
      ovf_d      = ovf_q;
      shadow_c_d = shadow_c_q;
      shadow_v_d = shadow_v_q;
      case (state_q)
         StIdle: begin
            if (|req_valid) begin
               op_a_d    = req_a[32'(gnt_idx) * W +: W];
               op_b_d    = req_b[32'(gnt_idx) * W +: W];
               op_aluc_d = req_aluc[32'(gnt_idx) * 4 +: 4];
               g_d       = gnt_idx;
               rr_d      = (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
               state_d   = StExec;
            end
         end
         StExec: begin
            resp_r_d        = alu_r;
            zero_d          = alu_zero;
            neg_d           = alu_negative;
            carry_d         = carry_sel;
            ovf_d           = ovf_sel;
            shadow_c_d[g_q] = carry_sel;
            shadow_v_d[g_q] = ovf_sel;
            state_d         = StResp;
         end
         StResp: begin
            if (resp_ready[g_q]) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_q       <= '0;
         g_q        <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_aluc_q  <= '0;
         resp_r_q   <= '0;
         zero_q     <= 1'b0;
         neg_q      <= 1'b0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         shadow_c_q <= '0;
         shadow_v_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         g_q        <= g_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_aluc_q  <= op_aluc_d;
         resp_r_q   <= resp_r_d;
         zero_q     <= zero_d;
         neg_q      <= neg_d;
         carry_q    <= carry_d;
         ovf_q      <= ovf_d;
         shadow_c_q <= shadow_c_d;
         shadow_v_q <= shadow_v_d;
      end
   end

   assign req_ready     = (state_q == StIdle) ? gnt : '0;
   assign resp_valid    = (state_q == StResp) ? (NREQ'(1) << g_q) : '0;
   assign resp_r        = resp_r_q;
   assign resp_zero     = zero_q;
   assign resp_carry    = carry_q;
   assign resp_negative = neg_q;
   assign resp_overflow = ovf_q;
   assign alu_a         = op_a_q;
   assign alu_b         = op_b_q;
   assign alu_aluc      = op_aluc_q;
   assign busy          = (state_q != StIdle);

endmodule
